ysyx_22040632_ifetch: RTL and testbench
=======================================

Name: ysyx_22040632_ifetch

Overview:
Instruction-fetch stage directly upstream of the icache. It owns the PC, drives the icache request interface (pc, valid, uncacheable) and receives ready plus 128-bit read data. From that data it extracts the 32-bit instruction and hands pc/inst to decode through a one-entry valid/ready output register. It also handles redirects (branch/jump/trap) and fence.i, including the case where an icache refill is already in flight and cannot be aborted.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
CACHE_BASE, 32'h8000_0000, start of cacheable window
CACHE_SIZE, 32'h0800_0000, size of cacheable window in bytes

Ports:
clk  in  1  clock
rrst_n  in  1  asynchronous active-low reset
ic_valid  out  1  fetch request to icache
ic_pc  out  32  fetch address
ic_uncacheable  out  1  request bypasses the cache
ic_ready  in  1  icache data valid this cycle
ic_inst  in  128  icache read data
fence_sig  out  1  one-cycle icache invalidate pulse
redirect_valid  in  1  redirect request from execute
redirect_pc  in  32  redirect target, word aligned
fence_i  in  1  fence.i request; target is fence_pc
fence_pc  in  32  restart address after fence.i
id_valid  out  1  output register holds an instruction
id_ready  in  1  decode accepts
id_pc  out  32  PC of the held instruction
id_inst  out  32  held instruction

Behaviour:
- Reset (async, rrst_n low): pc=RESET_PC, state=FETCH, id_valid=0, id_pc=0, id_inst=0, fence_sig=0, ic_valid=0. In the first cycle after reset release, ic_valid=1.
- ic_pc=pc. ic_uncacheable=1 iff pc<CACHE_BASE or pc>=CACHE_BASE+CACHE_SIZE; compare in 33-bit arithmetic so the window end does not wrap.
- Instruction extraction:
  - cacheable: word pc[3:2] of ic_inst (0 → bits[31:0] … 3 → bits[127:96]).
  - uncacheable: ic_inst[63:0], word pc[2].
- Request handshake: while ic_valid=1, ic_pc and ic_uncacheable are held stable until the cycle ic_ready=1. A transfer completes when ic_valid && ic_ready.
- Output register:
  - slot_free = !id_valid || id_ready.
  - ic_valid = (state==FETCH) && slot_free, or (state==DRAIN).
  - On a completed transfer in FETCH: id_pc<=pc, id_inst<=extracted word, id_valid<=1, pc<=pc+4 (32-bit wrap).
  - If id_ready and no completed transfer: id_valid<=0.
- States:
  - FETCH: normal operation as above.
  - DRAIN: a redirect/fence arrived while the request was outstanding (ic_valid=1, ic_ready=0). The request stays asserted with the old pc until ic_ready, because an icache refill is not abortable. The returned data is discarded and not written to id_*. Then → FENCE if a fence is pending, else → FETCH with pc=saved target.
  - FENCE: fence_sig=1 for exactly one cycle, ic_valid=0. Next cycle → FETCH with pc=fence_pc saved.
- Redirect/fence in FETCH:
  - id_valid<=0 the same clock (squash the held instruction).
  - Target captured into a pending register.
  - If no outstanding, unaccepted request: pc<=target and go to FETCH (redirect) or FENCE (fence).
  - A transfer completing in the same cycle as a redirect is discarded.
- Priority: fence_i > redirect_valid. A redirect during DRAIN or FENCE overwrites the pending target. A fence during DRAIN sets fence pending.
- fence_sig is never asserted while ic_valid=1.
- Back-to-back hits sustain one instruction per cycle when id_ready=1.

Test Plan:
- Reset release, cacheable hits with ic_ready=1 every cycle, id_ready=1 -> id_pc=0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; id_inst = ic_inst word 0, 1, 2.
- id_ready=0 for 3 cycles with id_valid=1 -> ic_valid=0, id_pc/id_inst stable, pc unchanged; id_ready=1 -> fetch resumes at next pc.
- pc=0x1000_0004 (outside window) -> ic_uncacheable=1, id_inst=ic_inst[63:32].
- Redirect to 0x8000_0100 while a miss is pending (ic_ready low for 10 cycles) -> ic_pc stays at the old pc until ic_ready; that data is dropped (id_valid=0); next request ic_pc=0x8000_0100.
- fence_i with fence_pc=0x8000_0040 while idle -> fence_sig high exactly 1 cycle with ic_valid=0, then ic_valid=1, ic_pc=0x8000_0040.
- fence_i and redirect_valid asserted in the same cycle -> fence wins; restart at fence_pc. Also: assert reset while in DRAIN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ysyx_22040632_ifetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22040632_ifetch : PC owner, icache request driver, decode output slot
// Revision: 1.0
// ---------------------------------------------------------------------------
module ysyx_22040632_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] CACHE_BASE = 32'h8000_0000,
  parameter logic [31:0] CACHE_SIZE = 32'h0800_0000
) (
  input  logic         clk,
  input  logic         rrst_n,
  output logic         ic_valid,
  output logic [31:0]  ic_pc,
  output logic         ic_uncacheable,
  input  logic         ic_ready,
  input  logic [127:0] ic_inst,
  output logic         fence_sig,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         fence_i,
  input  logic [31:0]  fence_pc,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [31:0]  id_pc,
  output logic [31:0]  id_inst
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_FENCE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        fence_pend_q, fence_pend_d;
  logic        fence_sig_q, fence_sig_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic [32:0] pc_ext, window_end;
  logic        uncacheable, slot_free, req, xfer, redir_any;
  logic [31:0] redir_target, pend_next, inst_word;

  // 33-bit compare keeps a window ending at 2^32 from wrapping to zero.
  assign pc_ext      = {1'b0, pc_q};
  assign window_end  = {1'b0, CACHE_BASE} + {1'b0, CACHE_SIZE};
  assign uncacheable = (pc_ext < {1'b0, CACHE_BASE}) || (pc_ext >= window_end);

  assign slot_free    = !id_valid_q || id_ready;
  assign req          = rrst_n && (((state_q == S_FETCH) && slot_free) || (state_q == S_DRAIN));
  assign xfer         = req && ic_ready;
  assign redir_any    = fence_i || redirect_valid;
  assign redir_target = fence_i ? fence_pc : redirect_pc;
  assign pend_next    = redir_any ? redir_target : pend_pc_q;

  always_comb begin
    inst_word = ic_inst[31:0];
    if (uncacheable) begin
      inst_word = pc_q[2] ? ic_inst[63:32] : ic_inst[31:0];
    end else begin
      case (pc_q[3:2])
        2'd0:    inst_word = ic_inst[31:0];
        2'd1:    inst_word = ic_inst[63:32];
        2'd2:    inst_word = ic_inst[95:64];
        default: inst_word = ic_inst[127:96];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    fence_pend_d = fence_pend_q;
    fence_sig_d  = 1'b0;
    id_valid_d   = id_ready ? 1'b0 : id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;

    case (state_q)
      S_FETCH: begin
        if (redir_any) begin
          id_valid_d   = 1'b0;
          pend_pc_d    = redir_target;
          fence_pend_d = fence_i;
          // An unaccepted refill cannot be aborted: wait it out in DRAIN.
          if (req && !ic_ready) begin
            state_d = S_DRAIN;
          end else begin
            pc_d = redir_target;
            if (fence_i) begin
              state_d     = S_FENCE;
              fence_sig_d = 1'b1;
            end
          end
        end else if (xfer) begin
          id_pc_d    = pc_q;
          id_inst_d  = inst_word;
          id_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
        end
      end
      S_DRAIN: begin
        pend_pc_d = pend_next;
        if (fence_i) begin
          fence_pend_d = 1'b1;
        end
        if (ic_ready) begin
          pc_d = pend_next;
          if (fence_pend_q || fence_i) begin
            state_d     = S_FENCE;
            fence_sig_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FENCE: begin
        pend_pc_d    = pend_next;
        pc_d         = pend_next;
        fence_pend_d = 1'b0;
        state_d      = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      fence_pend_q <= 1'b0;
      fence_sig_q  <= 1'b0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_inst_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      fence_pend_q <= fence_pend_d;
      fence_sig_q  <= fence_sig_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
    end
  end

  assign ic_valid       = req;
  assign ic_pc          = pc_q;
  assign ic_uncacheable = uncacheable;
  assign fence_sig      = fence_sig_q;
  assign id_valid       = id_valid_q;
  assign id_pc          = id_pc_q;
  assign id_inst        = id_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_ifetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ysyx_22040632_ifetch : directed + random bench with a stream-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ysyx_22040632_ifetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rrst_n = 1'b0;
  logic         ic_valid, ic_uncacheable, fence_sig, id_valid;
  logic [31:0]  ic_pc, id_pc, id_inst;
  logic         ic_ready = 1'b0, redirect_valid = 1'b0, fence_i = 1'b0, id_ready = 1'b0;
  logic [127:0] ic_inst = '0;
  logic [31:0]  redirect_pc = '0, fence_pc = '0;

  int n_checks = 0;
  int n_err    = 0;

  // Stream model: decode must see consecutive PCs from the latest target,
  // and the instruction at any address a is always mem_word(a).
  logic [31:0] exp_pc   = RESET_PC;
  logic        prev_out = 1'b0;
  logic [31:0] prev_pc  = '0;
  logic        fence_owed = 1'b0;
  int          accepts  = 0;

  ysyx_22040632_ifetch dut (
    .clk(clk), .rrst_n(rrst_n),
    .ic_valid(ic_valid), .ic_pc(ic_pc), .ic_uncacheable(ic_uncacheable),
    .ic_ready(ic_ready), .ic_inst(ic_inst), .fence_sig(fence_sig),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fence_i(fence_i), .fence_pc(fence_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic is_unc(input logic [31:0] a);
    longint p;
    p = {32'h0, a};
    return (p < 64'h8000_0000) || (p >= 64'h8000_0000 + 64'h0800_0000);
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000 + {22'd0, r[7:0], 2'b00};
      1:       return 32'h1000_0000 + {22'd0, r[7:0], 2'b00};
      2:       return 32'h87FF_FFF0;
      3:       return 32'h7FFF_FFF8;
      4:       return 32'hFFFF_FFF8;
      default: return {5'b10000, r[26:2], 2'b00};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller sets inputs; this drives icache data for ic_pc, checks, then clocks.
  task automatic step();
    logic [31:0] a;
    #1;
    if (is_unc(ic_pc)) begin
      a = ic_pc & ~32'h7;
      ic_inst = {$urandom(), $urandom(), mem_word(a + 32'd4), mem_word(a)};
    end else begin
      a = ic_pc & ~32'hF;
      ic_inst = {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
    end
    #1;
    if (rrst_n) begin
      if (prev_out) begin
        chk("hold_valid", {31'd0, ic_valid}, 32'd1);
        chk("hold_pc", ic_pc, prev_pc);
      end
      if (ic_valid) chk("uncacheable", {31'd0, ic_uncacheable}, {31'd0, is_unc(ic_pc)});
      if (fence_sig) begin
        chk("fence_no_req", {31'd0, ic_valid}, 32'd0);
        chk("fence_owed", {31'd0, fence_owed}, 32'd1);
        fence_owed = 1'b0;
      end
      if (id_valid && id_ready) begin
        chk("stream_pc", id_pc, exp_pc);
        chk("stream_inst", id_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (fence_i) begin
        exp_pc = fence_pc;
        fence_owed = 1'b1;
      end else if (redirect_valid) begin
        exp_pc = redirect_pc;
      end
      prev_out = ic_valid && !ic_ready;
      prev_pc  = ic_pc;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold_pc, hold_inst;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ic_valid", {31'd0, ic_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_fence_sig", {31'd0, fence_sig}, 32'd0);

    // Release and stream three cacheable hits
    rrst_n = 1'b1; ic_ready = 1'b1; id_ready = 1'b1;
    #1;
    chk("rel_ic_valid", {31'd0, ic_valid}, 32'd1);
    chk("rel_ic_pc", ic_pc, RESET_PC);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hit_valid", {31'd0, id_valid}, 32'd1);
      chk("hit_pc", id_pc, RESET_PC + 32'(4 * k));
      chk("hit_inst", id_inst, mem_word(RESET_PC + 32'(4 * k)));
    end

    // Decode back-pressure
    id_ready = 1'b0;
    #1;
    chk("bp_ic_valid", {31'd0, ic_valid}, 32'd0);
    hold_pc = id_pc; hold_inst = id_inst;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ic_valid", {31'd0, ic_valid}, 32'd0);
      chk("bp_id_pc", id_pc, hold_pc);
      chk("bp_id_inst", id_inst, hold_inst);
      chk("bp_ic_pc", ic_pc, hold_pc + 32'd4);
    end
    id_ready = 1'b1;
    step();
    chk("bp_resume", id_pc, hold_pc + 32'd4);

    // Uncacheable fetch at an odd word
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0004;
    step();
    redirect_valid = 1'b0;
    chk("unc_pc", ic_pc, 32'h1000_0004);
    chk("unc_flag", {31'd0, ic_uncacheable}, 32'd1);
    step();
    chk("unc_id_pc", id_pc, 32'h1000_0004);
    chk("unc_word", id_inst, ic_inst[63:32]);

    // Redirect while a miss is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    step();
    redirect_valid = 1'b0; ic_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk("drain_valid", {31'd0, ic_valid}, 32'd1);
      chk("drain_pc", ic_pc, 32'h8000_0200);
      chk("drain_id_valid", {31'd0, id_valid}, 32'd0);
      step();
    end
    ic_ready = 1'b1;
    step();
    chk("drop_id_valid", {31'd0, id_valid}, 32'd0);
    chk("drop_next_pc", ic_pc, 32'h8000_0100);
    step();
    chk("redir_id_pc", id_pc, 32'h8000_0100);

    // fence.i while idle
    fence_i = 1'b1; fence_pc = 32'h8000_0040;
    step();
    fence_i = 1'b0;
    chk("fence_pulse", {31'd0, fence_sig}, 32'd1);
    chk("fence_no_valid", {31'd0, ic_valid}, 32'd0);
    step();
    chk("fence_done", {31'd0, fence_sig}, 32'd0);
    chk("fence_restart_v", {31'd0, ic_valid}, 32'd1);
    chk("fence_restart_pc", ic_pc, 32'h8000_0040);

    // fence.i beats redirect
    fence_i = 1'b1; fence_pc = 32'h8000_0080;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    fence_i = 1'b0; redirect_valid = 1'b0;
    chk("prio_pulse", {31'd0, fence_sig}, 32'd1);
    step();
    chk("prio_pc", ic_pc, 32'h8000_0080);

    // Random traffic against the stream model
    for (int n = 0; n < 2000; n++) begin
      ic_ready = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = pick_target();
      fence_i = !fence_sig && ($urandom_range(0, 39) == 0);
      fence_pc = pick_target();
      step();
    end
    redirect_valid = 1'b0; fence_i = 1'b0; ic_ready = 1'b1; id_ready = 1'b1;
    repeat (4) step();
    chk("liveness", {31'd0, accepts > 500}, 32'd1);

    // Reset asserted while draining
    ic_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
    step();
    redirect_valid = 1'b0;
    chk("pre_rst_drain", {31'd0, ic_valid}, 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("arst_ic_valid", {31'd0, ic_valid}, 32'd0);
    chk("arst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("arst_id_pc", id_pc, 32'd0);
    chk("arst_id_inst", id_inst, 32'd0);
    chk("arst_fence_sig", {31'd0, fence_sig}, 32'd0);
    chk("arst_ic_pc", ic_pc, RESET_PC);
    prev_out = 1'b0; fence_owed = 1'b0; exp_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rrst_n = 1'b1; ic_ready = 1'b1;
    #1;
    chk("rerel_valid", {31'd0, ic_valid}, 32'd1);
    chk("rerel_pc", ic_pc, RESET_PC);
    repeat (3) step();
    chk("rerel_stream", id_pc, RESET_PC + 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
